// File: rtl/counter_flopr.sv
// counter_flopr: loadable up-counter plus an independent data register.
// Both are cleared asynchronously by an active-low reset.
//
// Ports:
//   clk       in   1       rising-edge clock
//   areset    in   1       async reset, active low (0 = clear)
//   enable    in   1       counter increment enable
//   load      in   1       counter parallel load, wins over enable
//   count_in  in   WIDTH   counter load value
//   count_out out  WIDTH   counter value, straight from a flop
//   d         in   DWIDTH  data register input
//   q         out  DWIDTH  data register output, straight from a flop
module counter_flopr #(
   parameter int WIDTH  = 21,
   parameter int DWIDTH = 1
) (
   input  logic              clk,
   input  logic              areset,
   input  logic              enable,
   input  logic              load,
   input  logic [WIDTH-1:0]  count_in,
   output logic [WIDTH-1:0]  count_out,
   input  logic [DWIDTH-1:0] d,
   output logic [DWIDTH-1:0] q
);

   logic [WIDTH-1:0]  r_count;
   logic [DWIDTH-1:0] r_q;
   logic [WIDTH-1:0]  w_count_inc;

   // Natural modulo-2^WIDTH wrap; no saturation.
   assign w_count_inc = r_count + WIDTH'(1'b1);

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= count_in;
      end else if (enable) begin
         r_count <= w_count_inc;
      end
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         r_q <= '0;
      end else begin
         r_q <= d;
      end
   end

   assign count_out = r_count;
   assign q         = r_q;

endmodule

// File: tb/tb_counter_flopr.sv
// tb_counter_flopr: directed and random stimulus for counter_flopr,
// scored against a queue of expected values filled by a reference model.
module tb_counter_flopr;

   localparam int WIDTH  = 21;
   localparam int DWIDTH = 1;
   localparam longint unsigned MODV = 64'd1 << WIDTH;

   logic              clk;
   logic              areset;
   logic              enable;
   logic              load;
   logic [WIDTH-1:0]  count_in;
   logic [WIDTH-1:0]  count_out;
   logic [DWIDTH-1:0] d;
   logic [DWIDTH-1:0] q;

   typedef struct {
      longint unsigned cnt;
      longint unsigned dq;
   } exp_t;

   exp_t exp_q[$];

   int n_cmp = 0;
   int n_err = 0;

   bit              m_valid = 0;
   longint unsigned m_cnt   = 0;
   longint unsigned m_q     = 0;

   counter_flopr #(
      .WIDTH  (WIDTH),
      .DWIDTH (DWIDTH)
   ) dut (
      .clk       (clk),
      .areset    (areset),
      .enable    (enable),
      .load      (load),
      .count_in  (count_in),
      .count_out (count_out),
      .d         (d),
      .q         (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   // Reference model: arithmetic on the behavioural rules.
   always @(posedge clk) begin
      if (!areset) begin
         m_cnt = 0;
         m_q   = 0;
      end else if (m_valid) begin
         if (load)
            m_cnt = longint'(count_in);
         else if (enable)
            m_cnt = (m_cnt + 1) % MODV;
         m_q = longint'(d);
      end
      if (m_valid)
         exp_q.push_back('{m_cnt, m_q});
   end

   // Reset clears both registers at once; anything pending is now 0.
   always @(negedge areset) begin
      m_valid = 1;
      m_cnt   = 0;
      m_q     = 0;
      foreach (exp_q[i]) exp_q[i] = '{0, 0};
   end

   // Monitor: outputs are always presented; compare once per cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("sb_count", 64'(count_out), e.cnt);
         chk("sb_q", 64'(q), e.dq);
      end
   end

   // Called at a falling edge; applies inputs for the next rising edge
   // and returns at the following falling edge.
   task automatic step(input logic en, input logic ld,
                       input logic [WIDTH-1:0] cin,
                       input logic [DWIDTH-1:0] dd);
      enable   = en;
      load     = ld;
      count_in = cin;
      d        = dd;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rst_pulse(input string nm);
      #2 areset = 1'b0;
      #1;
      chk({nm, "_count"}, 64'(count_out), 64'd0);
      chk({nm, "_q"}, 64'(q), 64'd0);
      #1 areset = 1'b1;
   endtask

   logic [0:3] dseq;

   initial begin
      areset   = 1'b1;
      enable   = 1'b0;
      load     = 1'b0;
      count_in = '0;
      d        = '0;
      dseq     = 4'b1011;

      // Reset between edges, seen before any clock edge.
      @(negedge clk);
      #2 areset = 1'b0;
      #1;
      chk("rst_count", 64'(count_out), 64'd0);
      chk("rst_q", 64'(q), 64'd0);
      @(posedge clk);
      #1;
      chk("rst_hold_count", 64'(count_out), 64'd0);
      @(negedge clk);
      areset = 1'b1;

      // Count 40, then hold 5.
      for (int i = 0; i < 40; i++)
         step(1'b1, 1'b0, WIDTH'($urandom), DWIDTH'($urandom));
      chk("count40", 64'(count_out), 64'd40);
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b0, WIDTH'($urandom), DWIDTH'($urandom));
      chk("hold40", 64'(count_out), 64'd40);

      // Load beats enable, then wrap from all-ones.
      step(1'b1, 1'b1, 21'h1FFFFF, 1'b0);
      chk("load_max", 64'(count_out), 64'h1FFFFF);
      step(1'b1, 1'b0, 21'h0ABCDE, 1'b0);
      chk("wrap", 64'(count_out), 64'd0);

      // Carry out of bit 4.
      step(1'b0, 1'b1, 21'd31, 1'b0);
      chk("load31", 64'(count_out), 64'd31);
      step(1'b1, 1'b0, 21'd0, 1'b0);
      chk("inc32", 64'(count_out), 64'd32);
      chk("inc32_hi", 64'(count_out[20:5]), 64'd1);
      chk("inc32_lo", 64'(count_out[4:0]), 64'd0);

      // Data register follows d one cycle late; counter unaffected.
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 21'h155555, dseq[i]);
         chk("dseq", 64'(q), 64'(dseq[i]));
      end
      chk("dseq_cnt", 64'(count_out), 64'd32);
      d = 1'b1;
      rst_pulse("dseq_rst");

      // Count to 100, short reset pulse, restart from 0.
      for (int i = 0; i < 100; i++)
         step(1'b1, 1'b0, WIDTH'($urandom), DWIDTH'($urandom));
      chk("count100", 64'(count_out), 64'd100);
      rst_pulse("mid_rst");
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, WIDTH'($urandom), DWIDTH'($urandom));
      chk("restart3", 64'(count_out), 64'd3);

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         logic ld;
         logic [WIDTH-1:0] cin;
         ld  = ($urandom_range(0, 9) == 0);
         cin = ($urandom_range(0, 3) == 0) ? 21'h1FFFF0 + 21'($urandom_range(0, 15))
                                           : WIDTH'($urandom);
         step(1'($urandom), ld, cin, DWIDTH'($urandom));
         if ($urandom_range(0, 59) == 0)
            rst_pulse("rnd_rst");
      end

      @(negedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
